// File: rtl/kotolv2_sched_pkg.sv
// Shared types and defaults for the edge event scheduler: FSM state
// encoding, parameter defaults and the grant index width.
package kotolv2_sched_pkg;

   localparam int N_REQ_DEF       = 4;
   localparam int DEAD_CYCLES_DEF = 8;
   localparam int GID_W           = 3;
   localparam int DROP_W          = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_DEAD  = 2'd2
   } sched_state_e;

endpackage

// File: rtl/edge_sync_fall.sv
// Two-flop synchronizer followed by a registered falling-edge detector.
// The strobe is one cycle wide and appears three cycles after the input falls.
module edge_sync_fall (
   input  logic clock,
   input  logic reset_n,
   input  logic async_i,
   output logic strobe_o
);

   logic meta_q;
   logic sync_q;
   logic prev_q;
   logic strobe_q;

   // The history flop resets low, so a line already low at release never
   // looks like a falling edge.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its neighbour.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         meta_q   <= 1'b0;
         sync_q   <= 1'b0;
         prev_q   <= 1'b0;
         strobe_q <= 1'b0;
      end else begin
         meta_q   <= async_i;
         sync_q   <= meta_q;
         prev_q   <= sync_q;
         strobe_q <= prev_q & ~sync_q;
      end
   end

   assign strobe_o = strobe_q;

endmodule

// File: rtl/edge_event_scheduler.sv
// Collects falling-edge events from asynchronous request lines and offers
// them one at a time as round-robin grants separated by a dead time.
module edge_event_scheduler
   import kotolv2_sched_pkg::*;
#(
   parameter int N_REQ       = N_REQ_DEF,
   parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [N_REQ-1:0]    req_signal,
   output logic                grant_valid,
   output logic [GID_W-1:0]    grant_id,
   input  logic                grant_ready,
   output logic [N_REQ-1:0]    pending,
   output logic [N_REQ-1:0]    overflow,
   output logic [DROP_W-1:0]   drop_count,
   input  logic                clear_status
);

   sched_state_e        state_q, state_d;
   logic [GID_W-1:0]    gid_q, gid_d;
   logic [GID_W-1:0]    last_q, last_d;
   logic [7:0]          dead_q, dead_d;
   logic [N_REQ-1:0]    pending_q, pending_d;
   logic [N_REQ-1:0]    overflow_q, overflow_d;
   logic [DROP_W-1:0]   drop_q, drop_d;

   logic [N_REQ-1:0]    strobe;
   logic [N_REQ-1:0]    clr_mask;
   logic [N_REQ-1:0]    drop;
   logic                accept;
   logic [GID_W-1:0]    win_hi, win_lo, winner;
   logic                hit_hi;
   logic [DROP_W:0]     drop_sum;

   for (genvar g = 0; g < N_REQ; g++) begin : g_sync
      edge_sync_fall u_sync (
         .clock    (clock),
         .reset_n  (reset_n),
         .async_i  (req_signal[g]),
         .strobe_o (strobe[g])
      );
   end

   // Round-robin: the lowest pending index above last_q wins, otherwise the
   // lowest pending index overall (the wrapped half of the search).
   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      win_hi = '0;
      win_lo = '0;
      hit_hi = 1'b0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            win_lo = GID_W'(i);
            if (GID_W'(i) > last_q) begin
               win_hi = GID_W'(i);
               hit_hi = 1'b1;
            end
         end
      end
      winner = hit_hi ? win_hi : win_lo;
   end

   always_comb begin
      state_d = state_q;
      gid_d   = gid_q;
      last_d  = last_q;
      dead_d  = dead_q;
      accept  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (|pending_q) begin
               gid_d   = winner;
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (grant_ready) begin
               accept  = 1'b1;
               last_d  = gid_q;
               dead_d  = 8'(DEAD_CYCLES);
               state_d = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (dead_q <= 8'd1) begin
               dead_d  = 8'd0;
               state_d = ST_IDLE;
            end else begin
               dead_d  = dead_q - 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A new event on the channel being accepted re-arms it rather than
   // counting as a drop: set wins over clear.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         clr_mask[i] = accept && (gid_q == GID_W'(i));
      end
      pending_d = (pending_q & ~clr_mask) | strobe;
      drop      = strobe & pending_q & ~clr_mask;
      drop_sum  = {1'b0, drop_q};
      for (int i = 0; i < N_REQ; i++) begin
         drop_sum = drop_sum + (DROP_W + 1)'(drop[i]);
      end
      if (clear_status) begin
         overflow_d = '0;
         drop_d     = '0;
      end else begin
         overflow_d = overflow_q | drop;
         drop_d     = drop_sum[DROP_W] ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         gid_q      <= '0;
         last_q     <= GID_W'(N_REQ - 1);
         dead_q     <= '0;
         pending_q  <= '0;
         overflow_q <= '0;
         drop_q     <= '0;
      end else begin
         state_q    <= state_d;
         gid_q      <= gid_d;
         last_q     <= last_d;
         dead_q     <= dead_d;
         pending_q  <= pending_d;
         overflow_q <= overflow_d;
         drop_q     <= drop_d;
      end
   end

   assign grant_valid = (state_q == ST_GRANT);
   assign grant_id    = grant_valid ? gid_q : '0;
   assign pending     = pending_q;
   assign overflow    = overflow_q;
   assign drop_count  = drop_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Directed bench for edge_event_scheduler: single grant, round-robin order,
// backpressure, overflow/saturation/clear, re-arm, and reset mid-dead-time.
module tb_edge_event_scheduler;

   logic       clock;
   logic       reset_n;
   logic [3:0] req_signal;
   logic       grant_valid;
   logic [2:0] grant_id;
   logic       grant_ready;
   logic [3:0] pending;
   logic [3:0] overflow;
   logic [7:0] drop_count;
   logic       clear_status;

   int n_cmp;
   int n_bad;
   int cycle;

   edge_event_scheduler #(
      .N_REQ       (4),
      .DEAD_CYCLES (8)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .req_signal   (req_signal),
      .grant_valid  (grant_valid),
      .grant_id     (grant_id),
      .grant_ready  (grant_ready),
      .pending      (pending),
      .overflow     (overflow),
      .drop_count   (drop_count),
      .clear_status (clear_status)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cycle);
      end
   endtask

   // Inputs change and outputs are sampled 1 ns after each rising edge.
   task automatic tick();
      @(posedge clock);
      #1;
      cycle++;
   endtask

   task automatic ticks(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      ticks(2);
      reset_n = 1'b1;
      ticks(4);
   endtask

   task automatic wait_valid(input string tag, input int budget);
      for (int k = 0; k < budget && !grant_valid; k++) tick();
      check(tag, grant_valid, 1);
   endtask

   int c_prev;
   int c_now;
   logic seen;

   initial begin
      n_cmp = 0; n_bad = 0; cycle = 0;
      reset_n = 1'b0; req_signal = 4'hF; grant_ready = 1'b0; clear_status = 1'b0;

      // ---------------- reset state ----------------
      do_reset();
      check("rst_valid",    grant_valid, 0);
      check("rst_id",       grant_id,    0);
      check("rst_pending",  pending,     0);
      check("rst_overflow", overflow,    0);
      check("rst_drops",    drop_count,  0);

      // ---------------- single event on ch2 ----------------
      grant_ready = 1'b1;
      req_signal[2] = 1'b0;
      ticks(3);
      check("t1_no_pend_yet", pending, 4'b0000);
      tick();
      check("t1_pending",    pending,     4'b0100);
      check("t1_valid_lat",  grant_valid, 0);
      tick();
      check("t1_valid",      grant_valid, 1);
      check("t1_id",         grant_id,    2);
      tick();
      check("t1_pend_clr",   pending,     4'b0000);
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         seen |= grant_valid;
         tick();
      end
      check("t1_dead_quiet", seen, 0);
      req_signal[2] = 1'b1;
      ticks(4);

      // ---------------- simultaneous events, round-robin ----------------
      do_reset();
      grant_ready = 1'b1;
      req_signal  = 4'h0;
      c_prev = 0;
      for (int n = 0; n < 4; n++) begin
         wait_valid($sformatf("t2_seen%0d", n), 30);
         check($sformatf("t2_id%0d", n), grant_id, n);
         if (n > 0) check($sformatf("t2_gap%0d", n), cycle - c_prev, 10);
         c_prev = cycle;
         tick();
      end
      check("t2_pend_empty", pending, 0);
      req_signal = 4'hF;
      ticks(12);

      // ---------------- backpressure ----------------
      do_reset();
      grant_ready = 1'b0;
      req_signal[1] = 1'b0;
      wait_valid("t3_seen", 10);
      seen = 1'b1;
      for (int k = 0; k < 20; k++) begin
         seen &= grant_valid & (grant_id == 3'd1);
         tick();
      end
      check("t3_stable", seen, 1);
      check("t3_id_hold", grant_id, 1);
      grant_ready = 1'b1;
      tick();
      check("t3_accepted", grant_valid, 0);
      check("t3_pend_clr", pending, 0);
      req_signal[1] = 1'b1;
      ticks(12);

      // ---------------- overflow, saturation, clear ----------------
      do_reset();
      grant_ready = 1'b0;
      req_signal[1] = 1'b0;
      ticks(4);
      check("t4_pending1", pending, 4'b0010);
      req_signal[1] = 1'b1;
      ticks(4);
      req_signal[1] = 1'b0;
      ticks(4);
      check("t4_ovf1",  overflow,   4'b0010);
      check("t4_drop1", drop_count, 1);
      check("t4_pend_kept", pending, 4'b0010);
      req_signal[1] = 1'b1;
      ticks(3);
      for (int k = 0; k < 300; k++) begin
         req_signal[1] = 1'b0;
         ticks(2);
         req_signal[1] = 1'b1;
         ticks(2);
      end
      ticks(6);
      check("t4_drop_sat", drop_count, 255);
      check("t4_ovf_sat",  overflow,   4'b0010);
      check("t4_still_granting", grant_id, 1);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      check("t4_clr_ovf",  overflow,   0);
      check("t4_clr_drop", drop_count, 0);

      // two new pendings, then three channels drop on the same edge
      req_signal[0] = 1'b0; req_signal[2] = 1'b0;
      ticks(3);
      req_signal[0] = 1'b1; req_signal[2] = 1'b1;
      ticks(4);
      check("t4_pend3", pending, 4'b0111);
      req_signal[2:0] = 3'b000;
      ticks(4);
      check("t4_multi_drop", drop_count, 3);
      check("t4_multi_ovf",  overflow,   4'b0111);
      req_signal[2:0] = 3'b111;
      ticks(4);

      // clear arriving on the same edge as a drop
      req_signal[1] = 1'b0;
      ticks(3);
      clear_status = 1'b1;
      tick();
      clear_status = 1'b0;
      check("t4_clrwin_drop", drop_count, 0);
      check("t4_clrwin_ovf",  overflow,   0);
      ticks(3);
      check("t4_clrwin_after", drop_count, 0);
      req_signal[1] = 1'b1;
      ticks(4);

      // ---------------- re-arm on acceptance ----------------
      do_reset();
      grant_ready = 1'b0;
      req_signal[3] = 1'b0;
      wait_valid("t5_seen", 10);
      check("t5_id", grant_id, 3);
      tick();
      req_signal[3] = 1'b1;
      ticks(4);
      req_signal[3] = 1'b0;
      ticks(3);
      check("t5_still_offer", grant_id, 3);
      c_now = cycle;
      grant_ready = 1'b1;
      tick();
      check("t5_accepted",  grant_valid, 0);
      check("t5_rearmed",   pending,     4'b1000);
      check("t5_no_drop",   drop_count,  0);
      check("t5_no_ovf",    overflow,    0);
      wait_valid("t5_seen2", 20);
      check("t5_id2",  grant_id, 3);
      check("t5_gap2", cycle - c_now, 10);
      tick();
      req_signal[3] = 1'b1;
      ticks(12);

      // ---------------- reset mid-DEAD ----------------
      do_reset();
      grant_ready = 1'b1;
      req_signal[0] = 1'b0;
      ticks(5);
      check("t6_grant0", grant_id, 0);
      tick();
      req_signal[1] = 1'b0; req_signal[3] = 1'b0;
      ticks(4);
      check("t6_pend", pending, 4'b1010);
      check("t6_in_dead", grant_valid, 0);
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_rst_pend",  pending,     0);
      check("t6_rst_valid", grant_valid, 0);
      check("t6_rst_id",    grant_id,    0);
      check("t6_rst_ovf",   overflow,    0);
      check("t6_rst_drop",  drop_count,  0);
      ticks(2);
      reset_n = 1'b1;
      seen = 1'b0;
      for (int k = 0; k < 20; k++) begin
         tick();
         seen |= grant_valid | (|pending);
      end
      check("t6_quiet_after_rst", seen, 0);
      req_signal[1] = 1'b1;
      ticks(4);
      req_signal[1] = 1'b0;
      wait_valid("t6_new_seen", 10);
      check("t6_new_id", grant_id, 1);
      ticks(12);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
